elevator_call_scheduler: RTL

//  Collects floor calls into a pending bitmap and dispatches them in SCAN (sweep) order.

---
 rtl/elevator_pkg.sv | 18 +
 rtl/elevator_floor_seek.sv | 38 +++
 rtl/elevator_call_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: direction encoding common with elevator_fsm and
// default floor geometry.
package elevator_pkg;

    localparam logic [1:0] DIR_UP   = 2'b00;
    localparam logic [1:0] DIR_DOWN = 2'b01;
    localparam logic [1:0] DIR_IDLE = 2'b11;

    localparam int unsigned DEF_FLOOR_W    = 4;
    localparam int unsigned DEF_NUM_FLOORS = 16;

    typedef enum logic [1:0] {
        S_UP   = DIR_UP,
        S_DOWN = DIR_DOWN,
        S_IDLE = DIR_IDLE
    } sched_state_t;

endpackage

// File: rtl/elevator_floor_seek.sv
// Combinational search of the pending bitmap: nearest pending floor at or above
// and at or below the current cab floor.
module elevator_floor_seek
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int unsigned FLOOR_W    = DEF_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic                  up_hit,
    output logic [FLOOR_W-1:0]    up_floor,
    output logic                  dn_hit,
    output logic [FLOOR_W-1:0]    dn_floor
);

    // Scan downward so the last match is the lowest floor >= cur_floor, and
    // upward so the last match is the highest floor <= cur_floor.
    always_comb begin
        up_hit   = 1'b0;
        up_floor = '0;
        dn_hit   = 1'b0;
        dn_floor = '0;
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) >= cur_floor)) begin
                up_hit   = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (pending[i] && (FLOOR_W'(i) <= cur_floor)) begin
                dn_hit   = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN-order call scheduler in front of elevator_fsm: pending-call bitmap,
// sweep direction FSM and registered empty/dout/rd dispatch port.
// Optional served/drop statistics counters are enabled by SCHED_STATS_EN.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int unsigned FLOOR_W    = DEF_FLOOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               call_valid,
    input  logic [FLOOR_W-1:0] call_floor,
    input  logic [FLOOR_W-1:0] cur_floor,
    output logic               req_empty,
    output logic [FLOOR_W-1:0] req_dout,
    input  logic               req_rd,
    output logic               call_drop
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]        served_cnt,
    output logic [7:0]         drop_cnt
`endif
);

    logic [NUM_FLOORS-1:0] pending;
    logic [NUM_FLOORS-1:0] pending_nxt;
    sched_state_t          state;
    sched_state_t          state_nxt;
    logic [FLOOR_W-1:0]    cur_clamp;
    logic                  up_hit;
    logic                  dn_hit;
    logic [FLOOR_W-1:0]    up_floor;
    logic [FLOOR_W-1:0]    dn_floor;
    logic [FLOOR_W-1:0]    up_dist;
    logic [FLOOR_W-1:0]    dn_dist;
    logic                  call_in_range;
    logic                  call_ok;
    logic                  pop;
    logic                  tgt_hit;
    logic [FLOOR_W-1:0]    tgt_floor;

    // Range checks run at 32 bits so NUM_FLOORS == 2**FLOOR_W does not truncate.
    assign call_in_range = (32'(call_floor) < NUM_FLOORS);
    assign call_ok       = call_valid && call_in_range;
    assign cur_clamp     = (32'(cur_floor) < NUM_FLOORS) ? cur_floor : FLOOR_W'(NUM_FLOORS - 1);
    assign pop           = req_rd && !req_empty;
    assign up_dist       = up_floor - cur_clamp;
    assign dn_dist       = cur_clamp - dn_floor;

    elevator_floor_seek #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_seek (
        .pending   (pending),
        .cur_floor (cur_clamp),
        .up_hit    (up_hit),
        .up_floor  (up_floor),
        .dn_hit    (dn_hit),
        .dn_floor  (dn_floor)
    );

    // Pop clears first so a same-floor call in the same cycle keeps the bit set.
    always_comb begin
        pending_nxt = pending;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (pop && (req_dout == FLOOR_W'(i))) begin
                pending_nxt[i] = 1'b0;
            end
            if (call_ok && (call_floor == FLOOR_W'(i))) begin
                pending_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pending != '0) begin
                    state_nxt = (up_hit && (!dn_hit || (up_dist <= dn_dist))) ? S_UP : S_DOWN;
                end
            end
            S_UP: begin
                if (!up_hit) begin
                    state_nxt = (pending != '0) ? S_DOWN : S_IDLE;
                end
            end
            S_DOWN: begin
                if (!dn_hit) begin
                    state_nxt = (pending != '0) ? S_UP : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Target follows the next direction so a reversal selects in the new sweep.
    always_comb begin
        tgt_hit   = 1'b0;
        tgt_floor = req_dout;
        case (state_nxt)
            S_UP: begin
                tgt_hit   = up_hit;
                tgt_floor = up_floor;
            end
            S_DOWN: begin
                tgt_hit   = dn_hit;
                tgt_floor = dn_floor;
            end
            default: begin
                tgt_hit   = 1'b0;
                tgt_floor = req_dout;
            end
        endcase
    end

    // The popped floor is still in this cycle's bitmap, so blank the port once.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_empty <= 1'b1;
            req_dout  <= '0;
            call_drop <= 1'b0;
        end else begin
            call_drop <= call_valid && !call_in_range;
            req_empty <= pop || !tgt_hit;
            if (tgt_hit && !pop) begin
                req_dout <= tgt_floor;
            end
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            served_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (pop && (served_cnt != 16'hFFFF)) begin
                served_cnt <= served_cnt + 16'd1;
            end
            if (call_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
